alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32, operand/result width.
REQ-002 Parameter MUL_CYCLES, default 3, execute cycles for MUL; legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_op  input  4  requester N opcode.
REQ-008 reqN_rs1  input  DATAWIDTH  requester N operand 1.
REQ-009 reqN_rs2  input  DATAWIDTH  requester N operand 2.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer takes result.
REQ-012 resp_data  output  DATAWIDTH  result.
REQ-013 resp_id  output  1  requester index that owns resp_data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 IDLE: exactly one requester granted when any reqN_valid high; reqN_ready = (state==IDLE) && grant==N, combinational.
REQ-017 Both valid: grant the requester not granted last (last_grant); single valid: grant it regardless of last_grant.
REQ-018 Handshake (reqN_valid && reqN_ready) latches op, rs1, rs2, id=N, updates last_grant=N, moves to EXEC; inputs not sampled otherwise.
REQ-019 EXEC entry loads cnt = MUL_CYCLES-1 for MUL, 0 otherwise; cnt != 0 decrements; cnt == 0 registers result into resp_data, moves to RESP.
REQ-020 Latency: accept at cycle T -> resp_valid high at T+2 (non-MUL), T+1+MUL_CYCLES (MUL).
REQ-021 RESP: resp_valid=1; resp_data, resp_id stable until resp_ready; resp_valid && resp_ready -> IDLE next cycle; no new accept in the handshake cycle.
REQ-022 Opcodes: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 LUI, 6 SLT, 7 SLTU, 8 XOR, 9 OR, 10 AND, 11 MUL; 12..15 execute as ADD.
REQ-023 Shift amount = rs2[4:0] for SLL/SRL/SRA; SRA sign-fills from rs1[31].
REQ-024 LUI result = {rs2[31:12], 12'h000}; SLT signed compare, SLTU unsigned, result 0 or 1.
REQ-025 ADD/SUB/MUL results are low DATAWIDTH bits, wrap-around, no overflow flag.
REQ-026 Minimum throughput: one operation per 3 cycles (IDLE, EXEC, RESP).

Reset
REQ-027 rst_n low at a rising edge: state=IDLE, cnt=0, resp_valid=0, resp_data=0, resp_id=0, last_grant=1 (req0 wins first tie), busy=0.
REQ-028 Reset in EXEC or RESP discards the in-flight operation; no response is produced for it.

Structure
REQ-029 Shared package holds opcode localparams (4-bit), FSM state encoding, and the arbiter response id width.
REQ-030 Datapath is one sub-module alu (combinational, ports rs1, rs2, op, rd), fed from the latched operands; arbiter owns all registers.

Verification
REQ-031 req0 only, ADD 5+7 accepted at T -> resp_valid at T+2, resp_data 12, resp_id 0.
REQ-032 After reset both valid same cycle, req0 SUB 3-5, req1 XOR 0xF0^0xFF -> req0 first (0xFFFFFFFE, id 0), then req1 (0x0000000F, id 1); repeated ties alternate.
REQ-033 MUL_CYCLES=3: MUL 7*6 at T -> 42 at T+4; MUL 0x00010000*0x00010000 -> 0x00000000.
REQ-034 SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF<1 -> 1; SLTU same -> 0; op 13, 2+2 -> 4.
REQ-035 resp_ready low 5 cycles in RESP -> resp_data/resp_id stable, both reqN_ready 0, busy 1; resp_ready high -> IDLE next cycle.
REQ-036 rst_n low during EXEC of a MUL -> next cycle resp_valid 0, busy 0; no response ever emitted for that MUL.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, FSM state encoding and response id width shared by
// the arbiter and its ALU datapath.
package alu_arbiter_pkg;
    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam int         ID_W    = 1;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU; opcodes 12..15 fall through to ADD.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [3:0]           op,
    input  logic [DATAWIDTH-1:0] rs1,
    input  logic [DATAWIDTH-1:0] rs2,
    output logic [DATAWIDTH-1:0] rd
);
    logic [4:0] w_shamt;
    assign w_shamt = rs2[4:0];
    always_comb begin
        case (op)
            OP_SLL:  rd = rs1 << w_shamt;
            OP_SRL:  rd = rs1 >> w_shamt;
            OP_SRA:  rd = $unsigned($signed(rs1) >>> w_shamt);
            OP_SUB:  rd = rs1 - rs2;
            OP_LUI:  rd = {rs2[DATAWIDTH-1:12], 12'h000};
            OP_SLT:  rd = {{(DATAWIDTH-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: rd = {{(DATAWIDTH-1){1'b0}}, rs1 < rs2};
            OP_XOR:  rd = rs1 ^ rs2;
            OP_OR:   rd = rs1 | rs2;
            OP_AND:  rd = rs1 & rs2;
            OP_MUL:  rd = rs1 * rs2;
            default: rd = rs1 + rs2;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single ALU with one
// operation in flight (IDLE -> EXEC -> RESP).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_op,
    input  logic [DATAWIDTH-1:0] req0_rs1,
    input  logic [DATAWIDTH-1:0] req0_rs2,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_op,
    input  logic [DATAWIDTH-1:0] req1_rs1,
    input  logic [DATAWIDTH-1:0] req1_rs2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATAWIDTH-1:0] resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);
    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [3:0]           r_op;
    logic [DATAWIDTH-1:0] r_rs1;
    logic [DATAWIDTH-1:0] r_rs2;
    logic [DATAWIDTH-1:0] r_data;
    logic [ID_W-1:0]      r_id;
    logic [ID_W-1:0]      r_last;
    logic                 w_idle;
    logic                 w_accept;
    logic [ID_W-1:0]      w_grant;
    logic [3:0]           w_op;
    logic [DATAWIDTH-1:0] w_rd;
    assign w_idle     = r_state == S_IDLE;
    // On a tie the requester that did not win last time goes first.
    assign w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign req0_ready = w_idle && req0_valid && (w_grant == '0);
    assign req1_ready = w_idle && req1_valid && (w_grant == ID_W'(1));
    assign w_accept   = req0_ready || req1_ready;
    assign w_op       = w_grant[0] ? req1_op : req0_op;
    assign resp_valid = r_state == S_RESP;
    assign resp_data  = r_data;
    assign resp_id    = r_id;
    assign busy       = !w_idle;
    alu_arbiter_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .op (r_op),
        .rs1(r_rs1),
        .rs2(r_rs2),
        .rd (w_rd)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= ID_W'(1);
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= w_op;
                    r_rs1   <= w_grant[0] ? req1_rs1 : req0_rs1;
                    r_rs2   <= w_grant[0] ? req1_rs2 : req0_rs2;
                    r_id    <= w_grant;
                    r_last  <= w_grant;
                    r_cnt   <= (w_op == OP_MUL) ? 4'(MUL_CYCLES - 1) : 4'd0;
                    r_state <= S_EXEC;
                end
                S_EXEC: if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_data  <= w_rd;
                    r_state <= S_RESP;
                end
                S_RESP: if (resp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random requests checked against an arithmetic
// reference model with its own arbitration and latency expectations.
module tb_alu_arbiter;
    logic        clk = 0, rst_n = 0;
    logic        req0_valid = 0, req1_valid = 0, resp_ready = 0;
    logic        req0_ready, req1_ready, resp_valid, busy;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
    logic [31:0] resp_data;
    logic [0:0]  resp_id;
    int          n_checks = 0, n_fail = 0;
    bit          last = 1;

    alu_arbiter #(.DATAWIDTH(32), .MUL_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sh;
        sh = int'(b[4:0]);
        p = {32'h0, a} * {32'h0, b};
        case (op)
            4'd0:  return a << sh;
            4'd1:  return a >> sh;
            4'd2:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd4:  return a - b;
            4'd5:  return b & 32'hFFFF_F000;
            4'd6:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a ^ b;
            4'd9:  return a | b;
            4'd10: return a & b;
            4'd11: return p[31:0];
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Presents up to two requests, holding the loser valid until it is served.
    task automatic run(input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input int hold);
        bit p0, p1, w;
        logic [31:0] exp;
        int n, lat;
        p0 = v0; p1 = v1;
        req0_op = o0; req0_rs1 = a0; req0_rs2 = b0;
        req1_op = o1; req1_rs1 = a1; req1_rs2 = b1;
        while (p0 || p1) begin
            @(negedge clk);
            req0_valid = p0; req1_valid = p1;
            #1;
            w = (p0 && p1) ? !last : p1;
            check("grant", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
            if (!req0_ready && !req1_ready) begin
                req0_valid = 0; req1_valid = 0;
                return;
            end
            exp  = w ? model(o1, a1, b1) : model(o0, a0, b0);
            lat  = ((w ? o1 : o0) == 4'd11) ? 4 : 2;
            last = w;
            @(posedge clk);
            @(negedge clk);
            if (w) p1 = 0; else p0 = 0;
            req0_valid = p0; req1_valid = p1;
            #1;
            check("exec_state", {busy, req0_ready, req1_ready, resp_valid}, 4'b1000);
            n = 1;
            while (!resp_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("latency", n, lat);
            check("resp_data", resp_data, exp);
            check("resp_id", resp_id, w);
            repeat (hold) begin
                @(negedge clk);
                check("hold", {resp_valid, busy, req0_ready, req1_ready, resp_id, resp_data},
                      {1'b1, 1'b1, 1'b0, 1'b0, w, exp});
            end
            resp_ready = 1; req0_valid = 0; req1_valid = 0;
            @(posedge clk);
            #1 resp_ready = 0;
            @(negedge clk);
            check("release", {resp_valid, busy}, 2'b00);
        end
    endtask

    task automatic reset_in_mul();
        bit seen;
        @(negedge clk);
        req0_op = 4'd11; req0_rs1 = 32'd7; req0_rs2 = 32'd6;
        req0_valid = 1; req1_valid = 0;
        #1 check("rst_grant", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        check("rst_exec_busy", busy, 1);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_clear", {resp_valid, busy, resp_id, resp_data}, 0);
        rst_n = 1;
        last = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check("no_resp_after_rst", seen, 0);
    endtask

    initial begin
        logic [1:0] v;
        repeat (2) @(negedge clk);
        check("reset", {resp_valid, busy, resp_id, resp_data, req0_ready, req1_ready}, 0);
        rst_n = 1;
        run(1, 4'd4, 32'd3, 32'd5, 1, 4'd8, 32'hF0, 32'hFF, 0);
        run(1, 4'd3, 32'd1, 32'd2, 1, 4'd3, 32'd10, 32'd20, 0);
        run(1, 4'd9, 32'h0F, 32'hF0, 1, 4'd10, 32'hFF, 32'h3C, 1);
        run(1, 4'd3, 32'd5, 32'd7, 0, 4'd0, 32'd0, 32'd0, 0);
        run(1, 4'd11, 32'd7, 32'd6, 0, 4'd0, 32'd0, 32'd0, 0);
        run(0, 4'd0, 32'd0, 32'd0, 1, 4'd11, 32'h0001_0000, 32'h0001_0000, 0);
        run(1, 4'd2, 32'h8000_0000, 32'd4, 0, 4'd0, 32'd0, 32'd0, 0);
        run(1, 4'd1, 32'h8000_0000, 32'd4, 0, 4'd0, 32'd0, 32'd0, 0);
        run(0, 4'd0, 32'd0, 32'd0, 1, 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
        run(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 0, 4'd0, 32'd0, 32'd0, 0);
        run(1, 4'd13, 32'd2, 32'd2, 0, 4'd0, 32'd0, 32'd0, 0);
        run(1, 4'd5, 32'd0, 32'hABCD_E123, 0, 4'd0, 32'd0, 32'd0, 0);
        run(1, 4'd0, 32'h0000_0001, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, 32'd0, 5);
        reset_in_mul();
        run(1, 4'd3, 32'd100, 32'd1, 1, 4'd4, 32'd0, 32'd1, 0);
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            run(v[0], 4'($urandom_range(0, 15)), $urandom, $urandom,
                v[1], 4'($urandom_range(0, 15)), $urandom, $urandom,
                int'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
